// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolved-branch update bundle shared by the fetch stage and the predictor.
// Optional stats outputs appear only when BP_STATS_EN is defined.
interface branch_predictor_if;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
`ifdef BP_STATS_EN
    logic [31:0] upd_count;
    logic [31:0] mispred_count;

    modport master (
        output fetch_pc, upd_vld, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_target, upd_count, mispred_count
    );
    modport slave (
        input  fetch_pc, upd_vld, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_target, upd_count, mispred_count
    );
`else
    modport master (
        output fetch_pc, upd_vld, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_target
    );
    modport slave (
        input  fetch_pc, upd_vld, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_target
    );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: 2-bit counter, tag and target per entry; learns from resolved branches.
// Latency: lookup is combinational (same cycle); updates land on the next posedge, no bypass.
// Backpressure: none, an update is accepted every cycle upd_vld is high. BP_STATS_EN adds counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic [31:0]      target;
    } entry_t;

    entry_t           table_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    entry_t           f_ent;
    entry_t           u_ent;
    logic             f_hit;
    logic             u_hit;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[31:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[31:IDX_W+2];
    assign f_ent = table_q[f_idx];
    assign u_ent = table_q[u_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    // Lookup sees the registered table only, so a same-cycle update is not forwarded.
    assign bp.pred_taken  = f_hit && f_ent.ctr[1];
    assign bp.pred_target = (f_hit && f_ent.ctr[1]) ? f_ent.target : bp.fetch_pc + 32'd4;

    assign ctr_inc = (u_ent.ctr == 2'b11) ? 2'b11 : u_ent.ctr + 2'd1;
    assign ctr_dec = (u_ent.ctr == 2'b00) ? 2'b00 : u_ent.ctr - 2'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: 32'h0};
            end
        end else if (bp.upd_vld) begin
            if (u_hit) begin
                if (bp.upd_taken) begin
                    table_q[u_idx].ctr    <= ctr_inc;
                    table_q[u_idx].target <= bp.upd_target;
                end else begin
                    table_q[u_idx].ctr    <= ctr_dec;
                end
            end else if (bp.upd_taken) begin
                // Taken miss evicts whatever alias occupied the slot; not-taken misses never allocate.
                table_q[u_idx] <= '{valid: 1'b1, tag: u_tag, ctr: 2'b10, target: bp.upd_target};
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] upd_count_q;
    logic [31:0] mispred_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_count_q     <= 32'h0;
            mispred_count_q <= 32'h0;
        end else if (bp.upd_vld) begin
            upd_count_q <= upd_count_q + 32'd1;
            if (bp.upd_pred_taken != bp.upd_taken) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign bp.upd_count     = upd_count_q;
    assign bp.mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench: driver pushes model predictions, a negedge monitor pops and compares.
module tb_branch_predictor;
    logic clk_i = 1'b0;
    logic rst_i;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bp    (bp)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] upd_cnt;
        logic [31:0] mis_cnt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Reference model: a 16-slot map keyed by pc word index, remembering the full upper pc bits.
    bit          m_valid [16];
    logic [31:0] m_upper [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_upd = 32'h0;
    logic [31:0] m_mis = 32'h0;

    logic        c_rst = 1'b1;
    logic        c_uv  = 1'b0;
    logic [31:0] c_upc = 32'h0;
    logic        c_ut  = 1'b0;
    logic [31:0] c_utg = 32'h0;
    logic        c_upt = 1'b0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int s;
        s  = slot(pc);
        tk = m_valid[s] && (m_upper[s] == pc / 64) && (m_ctr[s] >= 2);
        tg = tk ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic void model_clock();
        int s;
        if (c_rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
                m_tgt[i]   = 32'h0;
                m_upper[i] = 32'h0;
            end
            m_upd = 32'h0;
            m_mis = 32'h0;
        end else if (c_uv) begin
            m_upd = m_upd + 32'd1;
            if (c_upt != c_ut) m_mis = m_mis + 32'd1;
            s = slot(c_upc);
            if (m_valid[s] && m_upper[s] == c_upc / 64) begin
                if (c_ut) begin
                    m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = c_utg;
                end else begin
                    m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (c_ut) begin
                m_valid[s] = 1'b1;
                m_upper[s] = c_upc / 64;
                m_ctr[s]   = 2;
                m_tgt[s]   = c_utg;
            end
        end
    endfunction

    task automatic step(input logic r, input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic upt, input bit chk);
        exp_t e;
        @(posedge clk_i);
        model_clock();
        #1;
        rst_i             = r;
        bp.fetch_pc       = fpc;
        bp.upd_vld        = uv;
        bp.upd_pc         = upc;
        bp.upd_taken      = ut;
        bp.upd_target     = utg;
        bp.upd_pred_taken = upt;
        c_rst = r; c_uv = uv; c_upc = upc; c_ut = ut; c_utg = utg; c_upt = upt;
        if (chk) begin
            model_predict(fpc, e.taken, e.target);
            e.upd_cnt = m_upd;
            e.mis_cnt = m_mis;
            e.id      = step_no;
            exp_q.push_back(e);
        end
        step_no++;
    endtask

    task automatic fetch(input logic [31:0] fpc);
        step(1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic upd(input logic [31:0] fpc, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic upt);
        step(1'b0, fpc, 1'b1, upc, ut, utg, upt, 1'b1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h4;
            1:       t = 32'h5;
            2:       t = 32'h03FF_FFFF;
            default: t = $urandom & 32'h03FF_FFFF;
        endcase
        return (t << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bp.pred_taken !== e.taken) begin
                errors++;
                $display("FAIL pred_taken step %0d: got %b want %b", e.id, bp.pred_taken, e.taken);
            end
            checks++;
            if (bp.pred_target !== e.target) begin
                errors++;
                $display("FAIL pred_target step %0d: got %h want %h", e.id, bp.pred_target, e.target);
            end
`ifdef BP_STATS_EN
            checks++;
            if (bp.upd_count !== e.upd_cnt) begin
                errors++;
                $display("FAIL upd_count step %0d: got %h want %h", e.id, bp.upd_count, e.upd_cnt);
            end
            checks++;
            if (bp.mispred_count !== e.mis_cnt) begin
                errors++;
                $display("FAIL mispred_count step %0d: got %h want %h", e.id, bp.mispred_count, e.mis_cnt);
            end
`endif
        end
    end

    initial begin
        logic r, uv, ut, upt;
        logic [31:0] fpc, upc;
        rst_i             = 1'b1;
        bp.fetch_pc       = 32'h0;
        bp.upd_vld        = 1'b0;
        bp.upd_pc         = 32'h0;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = 32'h0;
        bp.upd_pred_taken = 1'b0;

        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Reset state and pc+4 wrap at the top of the address space.
        fetch(32'h100);
        fetch(32'hFFFF_FFFC);
        // First allocation; the same-cycle lookup still sees the empty slot.
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0);
        fetch(32'h100);
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1);
        fetch(32'h100);
        upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1);
        fetch(32'h100);
        // Not-taken at an empty slot must not allocate.
        upd(32'h200, 32'h208, 1'b0, 32'h444, 1'b0);
        fetch(32'h208);
        // Alias at the same slot evicts the older branch.
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0);
        fetch(32'h100);
        upd(32'h140, 32'h140, 1'b1, 32'h200, 1'b0);
        fetch(32'h100);
        fetch(32'h140);
        // Idle update inputs with upd_vld low leave the table alone.
        step(1'b0, 32'h140, 1'b0, 32'h140, 1'b0, 32'h999, 1'b1, 1'b1);
        fetch(32'h140);
        // Reset beats a simultaneous update.
        step(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b1);
        fetch(32'h140);

`ifdef BP_STATS_EN
        upd(32'h0, 32'h10, 1'b1, 32'h40, 1'b1);
        upd(32'h0, 32'h10, 1'b1, 32'h40, 1'b0);
        upd(32'h0, 32'h14, 1'b0, 32'h0, 1'b0);
        upd(32'h0, 32'h10, 1'b0, 32'h0, 1'b1);
        upd(32'h0, 32'h18, 1'b1, 32'h50, 1'b1);
        fetch(32'h0);
        checks++;
        if (m_upd !== 32'd5 || m_mis !== 32'd2) begin
            errors++;
            $display("FAIL stats_model: upd %0d mis %0d want 5 2", m_upd, m_mis);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.upd_count_q = 32'hFFFF_FFFF;
        release dut.upd_count_q;
        force dut.mispred_count_q = 32'hFFFF_FFFF;
        release dut.mispred_count_q;
        m_upd = 32'hFFFF_FFFF;
        m_mis = 32'hFFFF_FFFF;
        upd(32'h0, 32'h10, 1'b1, 32'h40, 1'b0);
        fetch(32'h0);
`endif

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            fpc = rand_pc();
            upc = ($urandom_range(0, 9) < 3) ? fpc : rand_pc();
            uv  = ($urandom_range(0, 1) == 1);
            ut  = ($urandom_range(0, 2) != 0);
            upt = ($urandom_range(0, 1) == 1);
            step(r, fpc, uv, upc, ut, $urandom & 32'hFFFF_FFFE, upt, 1'b1);
        end
        fetch(32'h100);

        repeat (3) @(posedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
